// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       extop,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  // Full op/func match; FETCH as the target marks an undecodable instruction.
  function automatic state_t decode_target(input logic [5:0] op_v, input logic [5:0] func_v);
    state_t tgt;
    case (op_v)
      OP_RTYPE: begin
        case (func_v)
          FN_ADDU, FN_SUBU, FN_SLT: tgt = S_EXEC_R;
          FN_JR:                    tgt = S_JR;
          default:                  tgt = S_FETCH;
        endcase
      end
      OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: tgt = S_EXEC_I;
      OP_LW, OP_SW:                      tgt = S_MEM_ADDR;
      OP_BEQ:                            tgt = S_BRANCH;
      OP_J:                              tgt = S_JUMP;
      OP_JAL:                            tgt = S_JAL;
      default:                           tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       mem_req_s, mem_we_s, iord_s, ir_write_s, mdr_write_s, pc_write_s;
  logic [1:0] pc_src_s, alu_src_b_s, reg_dst_s, mem_to_reg_s;
  logic       alu_src_a_s, extop_s, reg_write_s, illegal_s, retire_s;
  logic [2:0] alu_op_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state_s = S_FETCH;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    mdr_write_s  = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'd0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'd0;
    alu_op_s     = ALU_ADD;
    extop_s      = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 2'd0;
    mem_to_reg_s = 2'd0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'd1;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only has to compare.
        alu_src_b_s  = 2'd3;
        extop_s      = 1'b1;
        next_state_s = decode_target(op, func);
        illegal_s    = (next_state_s == S_FETCH);
      end
      S_EXEC_R: begin
        alu_src_a_s  = 1'b1;
        next_state_s = S_WB_R;
        case (func)
          FN_SUBU: alu_op_s = ALU_SUB;
          FN_SLT:  alu_op_s = ALU_SLT;
          default: alu_op_s = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'd2;
        next_state_s = S_WB_I;
        case (op)
          OP_ORI:  alu_op_s = ALU_OR;
          OP_LUI:  alu_op_s = ALU_LUI;
          default: begin
            alu_op_s = ALU_ADD;
            extop_s  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        extop_s     = 1'b1;
        if (op == OP_SW) begin
          next_state_s = S_MEM_WR;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req_s   = 1'b1;
        iord_s      = 1'b1;
        mdr_write_s = mem_ready;
        if (mem_ready) begin
          next_state_s = S_WB_MEM;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
        retire_s  = mem_ready;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_WB_R: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 2'd1;
        retire_s    = 1'b1;
      end
      S_WB_I: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 2'd1;
        retire_s     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_SUB;
        pc_src_s    = 2'd1;
        pc_write_s  = zero;
        retire_s    = 1'b1;
      end
      S_JUMP: begin
        pc_src_s   = 2'd2;
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_JAL: begin
        pc_src_s     = 2'd2;
        pc_write_s   = 1'b1;
        reg_write_s  = 1'b1;
        reg_dst_s    = 2'd2;
        mem_to_reg_s = 2'd2;
        retire_s     = 1'b1;
      end
      S_JR: begin
        pc_src_s   = 2'd3;
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // Reset gates every output so no enable can glitch while rst_n is low.
  assign mem_req    = rst_n & mem_req_s;
  assign mem_we     = rst_n & mem_we_s;
  assign iord       = rst_n & iord_s;
  assign ir_write   = rst_n & ir_write_s;
  assign mdr_write  = rst_n & mdr_write_s;
  assign pc_write   = rst_n & pc_write_s;
  assign pc_src     = {2{rst_n}} & pc_src_s;
  assign alu_src_a  = rst_n & alu_src_a_s;
  assign alu_src_b  = {2{rst_n}} & alu_src_b_s;
  assign alu_op     = {3{rst_n}} & alu_op_s;
  assign extop      = rst_n & extop_s;
  assign reg_write  = rst_n & reg_write_s;
  assign reg_dst    = {2{rst_n}} & reg_dst_s;
  assign mem_to_reg = {2{rst_n}} & mem_to_reg_s;
  assign illegal    = rst_n & illegal_s;
  assign retire     = rst_n & retire_s;
  assign state      = {4{rst_n}} & state_r;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle MIPS datapath. It replaces per-instruction combinational decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a shared unified memory port using a req/ready handshake. It drives every mux select and write enable of the datapath (PC, IR, register file, ALU, memory) and supports addu, subu, slt, jr, ori, lui, addi/addiu, lw, sw, beq, j and jal.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag (A − B == 0)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write when 1, read when 0; meaningful only with mem_req
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  unconditional PC load
- pc_src  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = register A (jr)
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2
- alu_op  out  3  0 = add, 1 = sub, 2 = or, 3 = slt, 4 = lui (imm << 16)
- extop  out  1  1 = sign-extend, 0 = zero-extend the immediate
- reg_write  out  1  register file write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (already PC+4)
- illegal  out  1  one-cycle pulse on an undecodable instruction
- retire  out  1  one-cycle pulse in the final cycle of each legal instruction
- state  out  4  current state, for debug

## Operation
States (encoding):
- FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WR = 6, WB_R = 7, WB_I = 8, WB_MEM = 9, BRANCH = 10, JUMP = 11, JAL = 12, JR = 13.
- Encodings 14–15 are unreachable. If entered, go to FETCH next cycle with all outputs 0.

Per-state outputs. Any output not listed is 0.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = add.
  - ir_write = pc_write = mem_ready, pc_src = 0.
  - Stay in FETCH while mem_ready = 0. Go to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = add, extop = 1 (branch target into ALUOut).
  - Next state by op/func:
    - op 000000 with func 100001 / 100011 / 101010 → EXEC_R.
    - op 000000 with func 001000 → JR.
    - op 001101, 001111, 001000, 001001 → EXEC_I.
    - op 100011 or 101011 → MEM_ADDR.
    - op 000100 → BRANCH.
    - op 000010 → JUMP.
    - op 000011 → JAL.
    - Anything else → FETCH with illegal = 1.
- EXEC_R: alu_src_a = 1, alu_src_b = 0.
  - alu_op: func 100001 → add, 100011 → sub, 101010 → slt.
  - Next state WB_R.
- EXEC_I: alu_src_a = 1, alu_src_b = 2.
  - ori → or with extop = 0. lui → lui with extop = 0. addi/addiu → add with extop = 1.
  - Next state WB_I.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, extop = 1, alu_op = add.
  - lw → MEM_RD. sw → MEM_WR.
- MEM_RD: mem_req = 1, mem_we = 0, iord = 1, mdr_write = mem_ready.
  - Hold while mem_ready = 0, then go to WB_MEM.
- MEM_WR: mem_req = 1, mem_we = 1, iord = 1, retire = mem_ready.
  - Hold while mem_ready = 0, then go to FETCH.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0, retire = 1. Next state FETCH.
- WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0, retire = 1. Next state FETCH.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1, retire = 1. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = sub, pc_src = 1, pc_write = zero, retire = 1. Next state FETCH.
- JUMP: pc_src = 2, pc_write = 1, retire = 1. Next state FETCH.
- JAL: pc_src = 2, pc_write = 1, reg_write = 1, reg_dst = 2, mem_to_reg = 2, retire = 1. Next state FETCH.
- JR: pc_src = 3, pc_write = 1, retire = 1. Next state FETCH.

Decode rules:
- Decode is a full match on op and, for op 000000, on func.
- An op-000000 instruction with an unlisted func is illegal.

## Timing
- Reset:
  - rst_n low forces state = FETCH immediately, asynchronously.
  - While rst_n is low, every output is forced to 0, including mem_req.
  - After rst_n deasserts, the first rising edge is spent in FETCH with mem_req = 1.
  - Reset asserted mid-instruction abandons that instruction. No write enable may glitch high during the assertion.
- Outputs:
  - Moore decodes of state, except the mem_ready-qualified ones: ir_write, pc_write in FETCH, mdr_write, retire in MEM_WR.
  - The BRANCH pc_write also depends combinationally on zero.
- Latency with zero-wait memory (mem_ready = 1 on first request):
  - j / jal / jr / beq: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Illegal instruction: 2 cycles.
- Each wait cycle on mem_ready adds exactly 1 cycle.
- Handshake:
  - mem_req, mem_we and iord stay stable from the first request cycle until the mem_ready cycle inclusive.
  - mem_req drops on the cycle after mem_ready.
  - Exception: FETCH following MEM_WR re-requests immediately (back-to-back requests allowed).
- retire pulses once per legal instruction. illegal and retire are never high together.

## Test plan
- Reset: rst_n = 0 mid-EXEC_R → state = 0 and all outputs 0 at once. After release, mem_req = 1 and iord = 0.
- addu (op 0, func 100001), mem_ready always 1 → states 0, 1, 2, 7, 0. WB_R shows reg_write = 1, reg_dst = 1, retire = 1. Total 4 cycles.
- lw (op 100011), 2 wait cycles in MEM_RD → MEM_RD lasts 3 cycles. mdr_write only in the 3rd. WB_MEM then shows mem_to_reg = 1. Total 7 cycles.
- beq (op 000100):
  - zero = 1 → pc_write = 1, pc_src = 1 in BRANCH.
  - zero = 0 → pc_write = 0.
  - Both cases: 3 cycles, retire = 1.
- jal (op 000011) → JAL shows reg_dst = 2, mem_to_reg = 2, pc_src = 2, pc_write = 1. Then jr (func 001000) → pc_src = 3.
- Illegal: op 111111, and op 0 with func 000000 → illegal pulse in DECODE, return to FETCH, no reg_write/pc_write beyond fetch, retire = 0.
